// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and default sizing shared by spi_txn_queue and its FIFOs.
package spi_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_DEPTH      = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_LOW,
      WAIT_DONE
   } spi_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO with a registered head word and a drop flag
// raised when a push is refused because the FIFO is full and nothing is popped.
module spi_sync_fifo
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty,
   output logic                  drop
);

   localparam int             AW         = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic                  push_ok, pop_ok;

   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);
   assign head  = head_q;

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      drop     = push && !push_ok;
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      head_d   = head_q;
      // The next head is the word being written when the FIFO was empty or about to drain to it.
      if (count_d == '0) begin
         head_d = '0;
      end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
         head_d = push_data;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/spi_txn_queue.sv
// spi_txn_queue: TX/RX word queues around an SPI master driver handshake.
// Define SPI_TXN_QUEUE_RX_EN to build the RX FIFO; otherwise received words are discarded.
module spi_txn_queue
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  start_transaction,
   output logic [DATA_WIDTH-1:0] data_in,
   input  logic                  ready,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  overflow
);

   spi_state_e            state_q, state_d;
   logic                  start_transaction_q, start_transaction_d;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic                  busy_q, busy_d;
   logic                  overflow_q, overflow_d;

   logic                  tx_empty, tx_pop, tx_drop;
   logic [DATA_WIDTH-1:0] tx_head;
   logic                  rx_capture, rx_drop;

   spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (full),
      .empty     (tx_empty),
      .drop      (tx_drop)
   );

`ifdef SPI_TXN_QUEUE_RX_EN
   logic unused_rx_full;

   spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_capture),
      .push_data (data_out),
      .pop       (rd_en),
      .head      (rd_data),
      .full      (unused_rx_full),
      .empty     (empty),
      .drop      (rx_drop)
   );
`else
   logic unused_rx;

   assign rd_data   = '0;
   assign empty     = 1'b1;
   assign rx_drop   = 1'b0;
   assign unused_rx = ^{rd_en, data_out, rx_capture};
`endif

   always_comb begin
      state_d    = state_q;
      data_in_d  = data_in_q;
      tx_pop     = 1'b0;
      rx_capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!tx_empty && ready) begin
               tx_pop    = 1'b1;
               data_in_d = tx_head;
               state_d   = START;
            end
         end
         START:     state_d = WAIT_LOW;
         WAIT_LOW:  if (!ready) state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (ready) begin
               rx_capture = 1'b1;
               state_d    = IDLE;
            end
         end
         default:   state_d = IDLE;
      endcase
      // Outputs are registered from the next state so they line up with the state register.
      start_transaction_d = (state_d == START);
      busy_d              = (state_d != IDLE);
      overflow_d          = overflow_q | tx_drop | rx_drop;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q             <= IDLE;
         start_transaction_q <= 1'b0;
         data_in_q           <= '0;
         busy_q              <= 1'b0;
         overflow_q          <= 1'b0;
      end else begin
         state_q             <= state_d;
         start_transaction_q <= start_transaction_d;
         data_in_q           <= data_in_d;
         busy_q              <= busy_d;
         overflow_q          <= overflow_d;
      end
   end

   assign start_transaction = start_transaction_q;
   assign data_in           = data_in_q;
   assign busy              = busy_q;
   assign overflow          = overflow_q;

endmodule
